led_blink_scheduler: RTL and testbench

//   Shares one board LED between NREQ requesters with a round-robin arbiter.

---
 rtl/led_sched_pkg.sv | 32 +++
 rtl/led_blink_scheduler_timer.sv | 30 +++
 rtl/led_blink_scheduler.sv | 168 ++++++++++++++++
 tb/tb_led_blink_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED blink scheduler.
package led_sched_pkg;

  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned GAP_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // One-hot winner: first set bit of req searching upward from ptr+1, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input logic [3:0]         n);
    logic [MAX_REQ-1:0] g;
    logic               hit;
    int unsigned        idx;
    g   = '0;
    hit = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % 32'(n);
      if ((k <= 32'(n)) && !hit && req[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        hit         = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_timer.sv
// Half-period timer: counts 0..d-1 while enabled and pulses tick on the wrap (d==0 acts as 1).
module blink_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic             tick
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_last;

  assign tick = en && (r_count == r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_last  <= '0;
    end else if (start) begin
      r_count <= '0;
      r_last  <= (d == '0) ? '0 : d - WIDTH'(1);
    end else if (en) begin
      r_count <= (r_count == r_last) ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin sharing of one LED between NREQ requesters, one blink burst per grant.
// Optional urgent preemption by requester 0 when LED_PREEMPT_EN is defined.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned SLOT_BEATS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] div,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  led
);

  localparam int unsigned IDX_W  = $clog2(NREQ);
  localparam int unsigned BEAT_W = $clog2(SLOT_BEATS + 1);

  if ((SLOT_BEATS < 2) || (SLOT_BEATS % 2 != 0)) begin : g_bad_beats
    $error("SLOT_BEATS must be even and >= 2");
  end
  if ((NREQ < 2) || (NREQ > MAX_REQ)) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end

  state_t            r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_owner;
  logic [BEAT_W-1:0] r_beat;

  logic [NREQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_force0;
  logic [WIDTH-1:0]  w_d;
  logic              w_start;
  logic              w_en;
  logic              w_tick;
  logic              w_owner_req;
  logic              w_cut;

`ifdef LED_PREEMPT_EN
  logic r_req0_q;
  logic r_pre_pend;
  logic r_pre_gap;
  logic w_pre_req;
`endif

  // Arbitration, timer control and preemption decode.
  always_comb begin
    logic [MAX_REQ-1:0] pick;
    pick      = rr_pick(MAX_REQ'(req), 3'(r_rr_ptr), 4'(NREQ));
    w_win_oh  = pick[NREQ-1:0];
    w_win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win_oh[i]) w_win_idx = IDX_W'(i);
    end
    w_force0 = 1'b0;
    w_cut    = 1'b0;
`ifdef LED_PREEMPT_EN
    w_pre_req = r_pre_pend || (req[0] && !r_req0_q);
    if ((r_state == GAP) && r_pre_gap && req[0]) begin
      w_win_oh  = NREQ'(1);
      w_win_idx = '0;
      w_force0  = 1'b1;
    end
    // Cut on the next toggle, or at once if the LED is already dark.
    w_cut = (r_state == RUN) && (r_owner != '0) && w_pre_req && (!led || w_tick);
`endif
    w_d         = div[w_win_idx*WIDTH +: WIDTH];
    w_start     = (r_state != RUN) && (req != '0);
    w_en        = (r_state == RUN);
    w_owner_req = req[r_owner];
  end

  blink_timer #(.WIDTH(WIDTH)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .en    (w_en),
    .d     (w_d),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= IDX_W'(NREQ - 1);
      r_owner  <= '0;
      r_beat   <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      led      <= 1'b0;
`ifdef LED_PREEMPT_EN
      r_req0_q   <= 1'b0;
      r_pre_pend <= 1'b0;
      r_pre_gap  <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef LED_PREEMPT_EN
      r_req0_q <= req[0];
`endif
      case (r_state)
        RUN: begin
          if (!w_owner_req) begin
            r_state <= GAP;
            grant   <= '0;
            led     <= 1'b0;
`ifdef LED_PREEMPT_EN
            r_pre_pend <= 1'b0;
`endif
          end else if (w_cut) begin
            r_state <= GAP;
            grant   <= '0;
            led     <= 1'b0;
`ifdef LED_PREEMPT_EN
            r_pre_pend <= 1'b0;
            r_pre_gap  <= 1'b1;
`endif
          end else begin
`ifdef LED_PREEMPT_EN
            if (w_pre_req && (r_owner != '0)) r_pre_pend <= 1'b1;
`endif
            if (w_tick) begin
              if (r_beat == BEAT_W'(SLOT_BEATS - 1)) begin
                r_state <= GAP;
                grant   <= '0;
                led     <= 1'b0;
                done    <= grant;
`ifdef LED_PREEMPT_EN
                r_pre_pend <= 1'b0;
`endif
              end else begin
                led    <= ~led;
                r_beat <= r_beat + BEAT_W'(1);
              end
            end
          end
        end
        default: begin
          // IDLE and the single GAP cycle share the arbitration path.
          led <= 1'b0;
`ifdef LED_PREEMPT_EN
          r_pre_gap <= 1'b0;
`endif
          if (req != '0) begin
            r_state <= RUN;
            grant   <= w_win_oh;
            r_owner <= w_win_idx;
            r_beat  <= '0;
            busy    <= 1'b1;
            if (!w_force0) r_rr_ptr <= w_win_idx;
          end else begin
            r_state <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Self-checking bench for led_blink_scheduler (NREQ=4, WIDTH=4, SLOT_BEATS=4).
module tb_led_blink_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] div;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        led;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_grant_q[$];
  logic [3:0] exp_done_q[$];
  logic [3:0] obs_grant_q[$];
  logic [3:0] obs_done_q[$];
  logic [3:0] prev_grant;

  led_blink_scheduler #(.NREQ(4), .WIDTH(4), .SLOT_BEATS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .div   (div),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each new grant and each done pulse as the DUT produces them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = 4'b0;
    end else begin
      if (grant != 4'b0 && prev_grant == 4'b0) obs_grant_q.push_back(grant);
      if (done != 4'b0) obs_done_q.push_back(done);
      prev_grant = grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_sb();
    exp_grant_q.delete(); exp_done_q.delete();
    obs_grant_q.delete(); obs_done_q.delete();
  endtask

  task automatic do_reset();
    req   = 4'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_sb();
  endtask

  task automatic compare_sb(input string name);
    logic [3:0] e;
    logic [3:0] o;
    checks++;
    if (obs_grant_q.size() !== exp_grant_q.size()) begin
      failures++;
      $display("FAIL %s grant_count actual=%0d required=%0d", name, obs_grant_q.size(), exp_grant_q.size());
    end
    while (obs_grant_q.size() > 0 && exp_grant_q.size() > 0) begin
      e = exp_grant_q.pop_front(); o = obs_grant_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s grant_order actual=%b required=%b", name, o, e); end
    end
    checks++;
    if (obs_done_q.size() !== exp_done_q.size()) begin
      failures++;
      $display("FAIL %s done_count actual=%0d required=%0d", name, obs_done_q.size(), exp_done_q.size());
    end
    while (obs_done_q.size() > 0 && exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = obs_done_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s done_order actual=%b required=%b", name, o, e); end
    end
  endtask

  task automatic test_reset();
    req = 4'b0; div = 16'h0; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, done, busy, led} !== 10'b0) begin
      failures++; $display("FAIL reset_outputs actual=%b required=%b", {grant, done, busy, led}, 10'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant, busy, led} !== 6'b0) begin
      failures++; $display("FAIL reset_idle actual=%b required=%b", {grant, busy, led}, 6'b0);
    end
  endtask

  task automatic test_single();
    logic exp_led;
    do_reset();
    div = 16'h0003; req = 4'b0001;
    exp_grant_q.push_back(4'b0001); exp_done_q.push_back(4'b0001);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_led = ((k - 1) / 3) % 2 == 1;
      checks++;
      if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant cyc=%0d actual=%b required=0001", k, grant); end
      checks++;
      if (led !== exp_led) begin failures++; $display("FAIL single_led cyc=%0d actual=%b required=%b", k, led, exp_led); end
    end
    @(negedge clk);
    checks++;
    if ({grant, done, busy, led} !== {4'b0000, 4'b0001, 1'b1, 1'b0}) begin
      failures++; $display("FAIL single_gap actual=%b required=%b", {grant, done, busy, led}, {4'b0000, 4'b0001, 1'b1, 1'b0});
    end
    req = 4'b0;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 5'b0) begin failures++; $display("FAIL single_idle actual=%b required=%b", {done, busy}, 5'b0); end
    compare_sb("single");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    div = 16'h1111; req = 4'b1111;
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100); exp_grant_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001); exp_done_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0100); exp_done_q.push_back(4'b1000);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp_g = ((c - 1) % 5 < 4) ? 4'(1 << (((c - 1) / 5) % 4)) : 4'b0;
      checks++;
      if (grant !== exp_g) begin failures++; $display("FAIL rr_grant cyc=%0d actual=%b required=%b", c, grant, exp_g); end
    end
    req = 4'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle busy actual=%b required=0", busy); end
    compare_sb("round_robin");
  endtask

  task automatic test_div_zero();
    logic exp_led;
    do_reset();
    div = 16'h0000; req = 4'b0100;
    exp_grant_q.push_back(4'b0100); exp_done_q.push_back(4'b0100);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_led = (k - 1) % 2 == 1;
      checks++;
      if ({grant, led} !== {4'b0100, exp_led}) begin
        failures++; $display("FAIL div0_burst cyc=%0d actual=%b required=%b", k, {grant, led}, {4'b0100, exp_led});
      end
    end
    @(negedge clk);
    checks++;
    if ({grant, done, led} !== {4'b0000, 4'b0100, 1'b0}) begin
      failures++; $display("FAIL div0_done actual=%b required=%b", {grant, done, led}, {4'b0000, 4'b0100, 1'b0});
    end
    req = 4'b0;
    repeat (2) @(negedge clk);
    compare_sb("div_zero");
  endtask

  task automatic test_abort();
    logic exp_led;
    do_reset();
    div = 16'h0050; req = 4'b0010;
    exp_grant_q.push_back(4'b0010);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_led = ((k - 1) / 5) % 2 == 1;
      checks++;
      if ({grant, led} !== {4'b0010, exp_led}) begin
        failures++; $display("FAIL abort_burst cyc=%0d actual=%b required=%b", k, {grant, led}, {4'b0010, exp_led});
      end
    end
    req = 4'b0;
    @(negedge clk);
    checks++;
    if ({grant, done, busy, led} !== {4'b0000, 4'b0000, 1'b1, 1'b0}) begin
      failures++; $display("FAIL abort_gap actual=%b required=%b", {grant, done, busy, led}, {4'b0000, 4'b0000, 1'b1, 1'b0});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle busy actual=%b required=0", busy); end
    compare_sb("abort");
  endtask

  task automatic test_async_reset();
    do_reset();
    div = 16'h0002; req = 4'b0001;
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0001);
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, led} !== {4'b0001, 1'b1}) begin
      failures++; $display("FAIL areset_pre actual=%b required=%b", {grant, led}, {4'b0001, 1'b1});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, done, busy, led} !== 10'b0) begin
      failures++; $display("FAIL areset_async actual=%b required=%b", {grant, done, busy, led}, 10'b0);
    end
    req = 4'b1111; div = 16'h1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL areset_first actual=%b required=0001", grant); end
    req = 4'b0;
    repeat (3) @(negedge clk);
    compare_sb("async_reset");
  endtask

`ifdef LED_PREEMPT_EN
  task automatic test_preempt();
    do_reset();
    div = 16'h1601; req = 4'b1100;
    exp_grant_q.push_back(4'b0100); exp_grant_q.push_back(4'b0001);
    exp_grant_q.push_back(4'b1000);
    exp_done_q.push_back(4'b0001);
    repeat (8) @(negedge clk);
    checks++;
    if ({grant, led} !== {4'b0100, 1'b1}) begin
      failures++; $display("FAIL preempt_pre actual=%b required=%b", {grant, led}, {4'b0100, 1'b1});
    end
    req = 4'b1101;
    repeat (4) @(negedge clk);
    checks++;
    if ({grant, led} !== {4'b0100, 1'b1}) begin
      failures++; $display("FAIL preempt_hold actual=%b required=%b", {grant, led}, {4'b0100, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({grant, done, led} !== 9'b0) begin
      failures++; $display("FAIL preempt_gap actual=%b required=%b", {grant, done, led}, 9'b0);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL preempt_grant actual=%b required=0001", grant); end
    repeat (5) @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin failures++; $display("FAIL preempt_next actual=%b required=1000", grant); end
    req = 4'b0;
    repeat (3) @(negedge clk);
    compare_sb("preempt");
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = 4'b0; div = 16'h0;
    prev_grant = 4'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_div_zero();
    test_abort();
    test_async_reset();
`ifdef LED_PREEMPT_EN
    test_preempt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
